// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding, the NOP loaded by flushes,
// and the bubble-length normalisation used by the stall controller.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_HOLD   = 2'd2
    } stall_state_e;

    // sll $0,$0,0 -- the canonical MIPS NOP written into flushed pipeline registers
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic [1:0] eff_len_m1(input logic [1:0] len);
        return (len == 2'd0) ? 2'd0 : 2'(len - 2'd1);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the five-stage core: turns load-use bubbles, mul/div busy
// and MEM-stage redirects into same-cycle write enables and flushes, with perf counters.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bubble_req,
    input  logic [1:0]       bubble_len,
    input  logic             md_busy,
    input  logic             redirect,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    stall_state_e state_q, state_d;
    logic [1:0]   rem_q, rem_d;
    logic         pend_q, pend_d;

    logic pc_we_c, ifid_we_c, idex_we_c;
    logic ifid_flush_c, idex_flush_c, exmem_flush_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            rem_q   <= 2'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        pc_we_c       = 1'b1;
        ifid_we_c     = 1'b1;
        idex_we_c     = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        state_d       = state_q;
        rem_d         = rem_q;
        pend_d        = pend_q;

        if (redirect) begin
            ifid_flush_c  = 1'b1;
            idex_flush_c  = 1'b1;
            exmem_flush_c = 1'b1;
            state_d       = ST_RUN;
            rem_d         = 2'd0;
            pend_d        = 1'b0;
        end else if (md_busy) begin
            pc_we_c   = 1'b0;
            ifid_we_c = 1'b0;
            idex_we_c = 1'b0;
            state_d   = ST_HOLD;
            // A fresh hazard seen while the front end freezes is remembered, not lost
            if (state_q == ST_RUN && bubble_req) begin
                rem_d  = eff_len_m1(bubble_len);
                pend_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bubble_req) begin
                        pc_we_c      = 1'b0;
                        ifid_we_c    = 1'b0;
                        idex_flush_c = 1'b1;
                        rem_d        = eff_len_m1(bubble_len);
                        state_d      = (eff_len_m1(bubble_len) != 2'd0) ? ST_BUBBLE : ST_RUN;
                    end
                end
                ST_BUBBLE: begin
                    pc_we_c      = 1'b0;
                    ifid_we_c    = 1'b0;
                    idex_flush_c = 1'b1;
                    rem_d        = 2'(rem_q - 2'd1);
                    state_d      = (rem_q > 2'd1) ? ST_BUBBLE : ST_RUN;
                end
                ST_HOLD: begin
                    // Leaving HOLD: a pending request owes 1+rem bubbles, otherwise rem are owed
                    if (pend_q) begin
                        pc_we_c      = 1'b0;
                        ifid_we_c    = 1'b0;
                        idex_flush_c = 1'b1;
                        pend_d       = 1'b0;
                        state_d      = (rem_q != 2'd0) ? ST_BUBBLE : ST_RUN;
                    end else if (rem_q != 2'd0) begin
                        pc_we_c      = 1'b0;
                        ifid_we_c    = 1'b0;
                        idex_flush_c = 1'b1;
                        rem_d        = 2'(rem_q - 2'd1);
                        state_d      = (rem_q > 2'd1) ? ST_BUBBLE : ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    rem_d   = 2'd0;
                    pend_d  = 1'b0;
                end
            endcase
        end
    end

    // Reset freezes the whole pipeline combinationally, independent of the clock
    assign pc_we       = pc_we_c & ~rst;
    assign ifid_we     = ifid_we_c & ~rst;
    assign idex_we     = idex_we_c & ~rst;
    assign ifid_flush  = ifid_flush_c & ~rst;
    assign idex_flush  = idex_flush_c & ~rst;
    assign exmem_flush = exmem_flush_c & ~rst;
    assign busy        = (state_q != ST_RUN);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~pc_we),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redirect),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios then random traffic,
// checked against an owed-bubble-count reference model.
module tb_pipe_stall_ctrl;

    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bubble_req = 1'b0;
    logic [1:0]       bubble_len = 2'd0;
    logic             md_busy = 1'b0;
    logic             redirect = 1'b0;
    logic             pc_we, ifid_we, idex_we;
    logic             ifid_flush, idex_flush, exmem_flush, busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bubble_req  (bubble_req),
        .bubble_len  (bubble_len),
        .md_busy     (md_busy),
        .redirect    (redirect),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .idex_we     (idex_we),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .busy        (busy),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] outs;
        int         stall;
        int         flush;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model: bubbles still owed, whether a mul/div freeze is in effect, counters
    int owed    = 0;
    bit held    = 1'b0;
    int m_stall = 0;
    int m_flush = 0;
    int cyc     = 0;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic step(input bit r, input bit req, input logic [1:0] len,
                        input bit md, input bit rd);
        exp_t e;
        int   eff;
        bit   pc, ifd, idx, fi, fd, fe, bz;
        @(posedge clk);
        #1;
        rst        = r;
        bubble_req = req;
        bubble_len = len;
        md_busy    = md;
        redirect   = rd;
        eff = (len == 2'd0) ? 1 : int'(len);
        pc = 1; ifd = 1; idx = 1; fi = 0; fd = 0; fe = 0;
        if (r) begin
            owed = 0; held = 0; m_stall = 0; m_flush = 0;
            pc = 0; ifd = 0; idx = 0;
            bz = 0;
        end else begin
            bz = (owed > 0) || held;
            if (rd) begin
                fi = 1; fd = 1; fe = 1;
                owed = 0; held = 0;
            end else if (md) begin
                pc = 0; ifd = 0; idx = 0;
                if (owed == 0 && !held && req) owed = eff;
                held = 1;
            end else if (owed > 0) begin
                pc = 0; ifd = 0; fd = 1;
                owed--;
                held = 0;
            end else if (held) begin
                held = 0;
            end else if (req) begin
                pc = 0; ifd = 0; fd = 1;
                owed = eff - 1;
            end
        end
        e.outs  = {pc, ifd, idx, fi, fd, fe, bz};
        e.stall = m_stall;
        e.flush = m_flush;
        e.cyc   = cyc;
        cyc++;
        if (!r && !pc && m_stall < SAT) m_stall++;
        if (!r && rd && m_flush < SAT) m_flush++;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t             e;
        logic [6:0]       got;
        logic [CNT_W-1:0] es, ef;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            got = {pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_flush, busy};
            es  = e.stall[CNT_W-1:0];
            ef  = e.flush[CNT_W-1:0];
            n_checks++;
            if (got === e.outs && stall_cnt === es && flush_cnt === ef) begin
                n_pass++;
            end else begin
                $display("FAIL cyc%0d ctrl got=%b exp=%b stall_cnt got=%0d exp=%0d flush_cnt got=%0d exp=%0d",
                         e.cyc, got, e.outs, stall_cnt, es, flush_cnt, ef);
            end
        end
    end

    initial begin
        int md_left = 0;
        bit r, q, m, d;
        logic [1:0] l;

        repeat (2) step(1, 0, 2'd0, 0, 0);
        repeat (5) step(0, 0, 2'd0, 0, 0);

        step(0, 1, 2'd1, 0, 0);
        repeat (3) step(0, 0, 2'd0, 0, 0);

        repeat (4) step(0, 1, 2'd3, 0, 0);
        repeat (4) step(0, 0, 2'd0, 0, 0);

        step(0, 1, 2'd2, 0, 0);
        repeat (3) step(0, 0, 2'd0, 1, 0);
        repeat (3) step(0, 0, 2'd0, 0, 0);

        step(0, 1, 2'd3, 0, 1);
        repeat (3) step(0, 0, 2'd0, 0, 0);

        step(0, 1, 2'd0, 1, 0);
        step(0, 0, 2'd0, 1, 0);
        repeat (3) step(0, 0, 2'd0, 0, 0);

        step(0, 1, 2'd3, 0, 0);
        step(0, 0, 2'd0, 0, 1);
        repeat (2) step(0, 0, 2'd0, 0, 0);

        step(0, 1, 2'd3, 0, 0);
        step(1, 0, 2'd0, 0, 0);
        repeat (3) step(0, 0, 2'd0, 0, 0);

        // Long random run also drives both counters into saturation
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            q = ($urandom_range(0, 99) < 35);
            l = 2'($urandom_range(0, 3));
            d = ($urandom_range(0, 99) < 7);
            if (md_left > 0) begin
                m = 1;
                md_left--;
            end else if ($urandom_range(0, 99) < 8) begin
                m = 1;
                md_left = $urandom_range(0, 3);
            end else begin
                m = 0;
            end
            step(r, q, l, m, d);
        end

        step(0, 0, 2'd0, 0, 0);
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain pending got=%0d exp=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
